inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit in the RISC-V core.
- Holds the PC and issues requests to instruction memory over a req/ack handshake with variable latency.
- Presents a stable 32-bit instruction word (inst) to the control unit and datapath.
- Takes the control unit's PCSel and the ALU result to select the next PC (pc+4 or branch/jump target).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
NOP_INST, 32'h0000_0013, value driven on inst when no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  core clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
PCSel  input  1  from control unit: 1 = next PC from ALU_out, 0 = pc+4.
ALU_out  input  32  branch/jump target computed by ALU.
advance  input  1  datapath commits the current instruction this cycle.
imem_req  output  1  instruction memory request.
imem_addr  output  32  word address of the request (always equal to pc).
imem_ack  input  1  memory returns imem_rdata this cycle.
imem_rdata  input  32  fetched instruction word.
inst  output  32  instruction to control unit/decoder.
inst_valid  output  1  inst holds a fetched instruction for pc.
pc  output  32  address of inst.
pc_plus4  output  32  pc + 4, for JAL/JALR writeback.
misalign  output  1  one-cycle pulse: redirect target had bit 1 set.

Behaviour:
- Reset is asynchronous and active-low (rst_n); single clock clk. All state is cleared immediately when rst_n=0.
- Reset values:
  - pc=RESET_PC, inst=NOP_INST, inst_valid=0, misalign=0.
  - FSM in IDLE, imem_req=0.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE:
    - imem_req=0.
    - Always moves to FETCH on the next clock.
    - The guard cycle after reset release discards any ack left over from before reset; imem_ack in IDLE is ignored.
  - FETCH:
    - imem_req=1 and imem_addr=pc; both stay stable until ack.
    - On imem_ack=1: inst<=imem_rdata, inst_valid<=1, go to HOLD.
    - A same-cycle ack (combinational memory) is legal.
  - HOLD:
    - imem_req=0; inst and pc are held stable.
    - advance=1: pc<=next_pc, inst_valid<=0, inst<=NOP_INST, go to FETCH.
    - advance=0: stay in HOLD.
- advance is ignored whenever inst_valid=0 (IDLE/FETCH).
- imem_ack is ignored outside FETCH.
- next_pc:
  - PCSel=0: pc+4.
  - PCSel=1: {ALU_out[31:2],2'b00}.
  - Bit 0 is cleared per the JALR rule; bit 1 is also forced to 0 since RV32I has no compressed instructions.
  - If PCSel=1 and ALU_out[1]=1, misalign=1 for exactly the cycle after the advance; otherwise misalign=0.
- Arithmetic:
  - pc+4 and pc_plus4 are 32-bit modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - pc_plus4 is combinational from pc.
- PCSel and ALU_out are sampled only on the advancing edge in HOLD; they are don't-care at all other times.
- Throughput: minimum 2 cycles per instruction (FETCH with immediate ack, then HOLD with advance).
- Latency: FETCH-state ack edge to inst_valid=1 is one clock.
- Reset mid-FETCH: the outstanding request is abandoned.
  - The FSM returns to IDLE and pc to RESET_PC.
  - The memory must drop any ack for the abandoned request by the end of the IDLE guard cycle.
- Simultaneous advance and imem_ack in HOLD: the ack is ignored and advance is taken.

Test Plan:
1. Reset and first fetch: release rst_n, then zero-latency memory -> IDLE 1 cycle, then imem_req=1 with imem_addr=0; imem_rdata=32'h00500093 -> next cycle inst=32'h00500093, inst_valid=1, pc=0, pc_plus4=4.
2. Sequential flow with 3-cycle ack latency -> imem_req and imem_addr held for 3 cycles; advance with PCSel=0 -> next fetch at pc=4, then 8; inst=NOP_INST and inst_valid=0 while waiting.
3. Redirect: HOLD at pc=0x10, PCSel=1, ALU_out=0x0000_0101, advance=1 -> pc=0x100, misalign=0 (bit 0 only). Repeat with ALU_out=0x102 -> pc=0x100 and misalign pulses 1 for one cycle.
4. Stall: hold advance=0 for 5 cycles in HOLD -> inst, pc and inst_valid constant, imem_req=0. Toggling imem_ack and imem_rdata during the stall has no effect.
5. Wrap: force pc=32'hFFFF_FFFC, advance with PCSel=0 -> next imem_addr=0, and pc_plus4=0 while pc=FFFF_FFFC.
6. Reset mid-FETCH: assert rst_n=0 while imem_req=1 and ack pending -> imem_req drops immediately, pc=RESET_PC, inst_valid=0. An ack during the IDLE cycle after release is ignored; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a variable-latency
// req/ack handshake and presents a stable instruction to the control unit.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSel,
    input  logic [31:0] ALU_out,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;
    logic        req_q;
    logic        misalign_q;
    logic [31:0] next_pc_d;

    assign pc_plus4 = pc_q + 32'd4;
    // Both low bits of a redirect target are dropped: no compressed ISA.
    assign next_pc_d = PCSel ? {ALU_out[31:2], 2'b00} : pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                // Guard cycle: any ack still in flight from before reset is dropped.
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        inst_q  <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc_q       <= next_pc_d;
                        inst_q     <= NOP_INST;
                        valid_q    <= 1'b0;
                        req_q      <= 1'b1;
                        misalign_q <= PCSel & ALU_out[1];
                        state_q    <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus pushes expected fetch
// addresses and instructions; a negedge monitor pops and compares them.
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSel;
    logic [31:0] ALU_out;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    inst_fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .PCSel(PCSel), .ALU_out(ALU_out),
        .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
        .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pp4;
    } exp_t;

    exp_t        inst_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        req_prev = 1'b0;
    logic        vld_prev = 1'b0;
    logic [31:0] last_pc;
    logic [31:0] last_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a new request is checked against the expected address, a newly
    // valid instruction against the expected fetch result.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (imem_req && !req_prev) begin
                if (addr_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
                else chk("req_addr", imem_addr, addr_q.pop_front());
            end
            if (inst_valid && !vld_prev) begin
                if (inst_q.size() == 0) chk("inst_unexpected", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = inst_q.pop_front();
                    chk("sb_inst", inst, e.inst);
                    chk("sb_pc", pc, e.pc);
                    chk("sb_pc_plus4", pc_plus4, e.pp4);
                end
            end
        end
        req_prev = imem_req;
        vld_prev = inst_valid;
    end

    // Memory side of one fetch: wait lat cycles with a stable request, then ack.
    // advance is asserted while waiting to show it is ignored in FETCH.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int lat);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            chk("req_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < lat; i++) begin
            imem_ack = 1'b0; advance = 1'b1; PCSel = 1'b1; ALU_out = $urandom;
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp_addr);
            chk("wait_valid", {31'd0, inst_valid}, 32'd0);
            chk("wait_inst", inst, NOP);
        end
        inst_q.push_back('{pc: exp_addr, inst: data, pp4: exp_addr + 32'd4});
        advance = 1'b0; imem_ack = 1'b1; imem_rdata = data;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        last_pc = exp_addr;
        last_inst = data;
    endtask

    // Advance out of HOLD with a simultaneous (ignored) ack.
    task automatic do_adv(input logic sel, input logic [31:0] alu, input logic [31:0] exp_pc,
                          input logic exp_mis);
        addr_q.push_back(exp_pc);
        advance = 1'b1; PCSel = sel; ALU_out = alu;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        advance = 1'b0; imem_ack = 1'b0; PCSel = ~sel; ALU_out = $urandom;
        chk("adv_pc", pc, exp_pc);
        chk("adv_misalign", {31'd0, misalign}, {31'd0, exp_mis});
        chk("adv_valid", {31'd0, inst_valid}, 32'd0);
        chk("adv_inst", inst, NOP);
        @(negedge clk);
        chk("misalign_pulse_end", {31'd0, misalign}, 32'd0);
    endtask

    // Release reset with a stale ack present during the IDLE guard cycle.
    task automatic release_rst();
        addr_q.push_back(RST_PC);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("guard_valid", {31'd0, inst_valid}, 32'd0);
        chk("guard_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; PCSel = 1'b0; ALU_out = '0; advance = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, NOP);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);

        // First fetch with zero-latency memory
        release_rst();
        fetch(32'h0, 32'h0050_0093, 0);

        // Sequential flow, 3-cycle latency
        do_adv(1'b0, 32'h0, 32'h4, 1'b0);
        fetch(32'h4, 32'h0010_8113, 3);
        do_adv(1'b0, 32'h0, 32'h8, 1'b0);
        fetch(32'h8, 32'h0020_0193, 3);
        do_adv(1'b0, 32'h0, 32'hC, 1'b0);
        fetch(32'hC, 32'h0030_0213, 1);
        do_adv(1'b0, 32'h0, 32'h10, 1'b0);
        fetch(32'h10, 32'h0000_0063, 0);

        // Redirects: bit 0 silently cleared, bit 1 flags misalign
        do_adv(1'b1, 32'h0000_0101, 32'h100, 1'b0);
        fetch(32'h100, 32'h0040_0293, 2);
        do_adv(1'b1, 32'h0000_0102, 32'h100, 1'b1);
        fetch(32'h100, 32'h0050_0313, 0);

        // Stall in HOLD with memory noise
        for (int i = 0; i < 5; i++) begin
            advance = 1'b0; imem_ack = $urandom; imem_rdata = $urandom;
            @(negedge clk);
            chk("stall_inst", inst, last_inst);
            chk("stall_pc", pc, last_pc);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0;

        // Wrap at the top of the address space
        do_adv(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        fetch(32'hFFFF_FFFC, 32'h0060_0393, 1);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        do_adv(1'b0, 32'h0, 32'h0, 1'b0);
        fetch(32'h0, 32'h0070_0413, 0);

        // Move off RESET_PC, then reset mid-FETCH
        do_adv(1'b1, 32'h0000_0204, 32'h204, 1'b0);
        fetch(32'h204, 32'h0080_0493, 0);
        do_adv(1'b0, 32'h0, 32'h208, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        release_rst();
        fetch(RST_PC, 32'h0090_0513, 1);

        @(negedge clk);
        chk("sb_drain_inst", inst_q.size(), 32'd0);
        chk("sb_drain_addr", addr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
